// File: rtl/sw_debounce.sv
// Two-channel slide-switch conditioner: 2-FF synchroniser, hold-time debounce
// counter and registered one-cycle rise/fall pulses per channel.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 19
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_IN0,
  input  logic SW_IN1,
  output logic SW0,
  output logic SW1,
  output logic RISE0,
  output logic RISE1,
  output logic FALL0,
  output logic FALL1
);

  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         rawIn;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         sw_q, sw_d;
  logic [1:0]         rise_q, rise_d;
  logic [1:0]         fall_q, fall_d;

  assign rawIn = {SW_IN1, SW_IN0};

  // A new level is accepted only after it has differed from the debounced
  // level on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] == sw_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CntLast) begin
        cnt_d[ch]  = '0;
        sw_d[ch]   = sync2_q[ch];
        rise_d[ch] = sync2_q[ch];
        fall_d[ch] = ~sync2_q[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign SW0   = sw_q[0];
  assign SW1   = sw_q[1];
  assign RISE0 = rise_q[0];
  assign RISE1 = rise_q[1];
  assign FALL0 = fall_q[0];
  assign FALL1 = fall_q[1];

endmodule
